dvs_event_fifo: RTL and testbench
=================================

DVS_EVENT_FIFO -- requirements
Module: dvs_event_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, event storage entries; SHALL be a power of two and at least 2.
REQ-002 Parameter DROP_CNT_BITS, default 16, width of the drop counter.
REQ-003 Port clk  input  1  single interface clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port event_x  input  DVS_X_ADDR_BITS  receiver event X address.
REQ-006 Port event_y  input  DVS_Y_ADDR_BITS  receiver event Y address.
REQ-007 Port event_timestamp  input  TIMESTAMP_US_BITS  receiver event time in microseconds.
REQ-008 Port event_polarity  input  1  receiver event polarity.
REQ-009 Port new_event  input  1  one-cycle strobe; event_* fields are valid in that cycle.
REQ-010 Port out_x, out_y, out_timestamp, out_polarity  output  same widths as inputs  head-of-queue event.
REQ-011 Port out_valid  output  1  queue is non-empty and out_* holds the head event.
REQ-012 Port out_ready  input  1  consumer accepts the head event when out_valid is high.
REQ-013 Port fill_level  output  $clog2(FIFO_DEPTH)+1  number of stored events.
REQ-014 Port overflow  output  1  sticky flag: an event was dropped because the queue was full.
REQ-015 Port clear_overflow  input  1  one-cycle pulse; clears overflow and drop_count.
REQ-016 Port drop_count  output  DROP_CNT_BITS  events dropped (full or out of range), saturating.

Function
REQ-017 Push: on a clk edge with new_event=1, the event SHALL be stored if it is in range and the queue is not full, or if it is full and a pop occurs in the same cycle.
REQ-018 Range check: an event with event_x >= DVS_WIDTH_PXLS or event_y >= DVS_HEIGHT_PXLS SHALL be discarded and SHALL increment drop_count; it SHALL NOT set overflow.
REQ-019 Pop: on a clk edge with out_valid=1 and out_ready=1, the head entry SHALL be removed.
REQ-020 Output timing: the queue is first-word-fall-through with registered storage; an event pushed into an empty queue at edge N SHALL appear on out_* with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-021 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop SHALL leave fill_level unchanged, at any fill level from 1 to FIFO_DEPTH.
REQ-023 A push into a full queue without a pop SHALL be discarded, SHALL set overflow, and SHALL increment drop_count.
REQ-024 drop_count SHALL saturate at all-ones; it SHALL NOT wrap.
REQ-025 If clear_overflow coincides with a drop, the clear SHALL win: overflow=0 and drop_count=0.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or by fill_level.
REQ-027 When out_valid=0, out_ready SHALL be ignored and the out_* values are don't-care.
REQ-028 Events SHALL leave in arrival order; timestamps pass through unmodified.

Reset
REQ-029 rst_n=0 SHALL immediately clear the pointers, fill_level, out_valid, overflow and drop_count, and drive out_* to 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored events; storage contents need not be cleared.

Structure
REQ-031 DVS_X_ADDR_BITS, DVS_Y_ADDR_BITS, TIMESTAMP_US_BITS, DVS_WIDTH_PXLS and DVS_HEIGHT_PXLS SHALL come from dvs_ravens_pkg.
REQ-032 A packed struct typedef dvs_event_t {x, y, timestamp, polarity} SHALL be added to dvs_ravens_pkg and used for the storage word.
REQ-033 Storage SHALL be one sub-module, dvs_sync_fifo, parameterised on word type and depth; range check and counters stay in the top level.

Verification
REQ-034 Reset, then one push (x=5, y=7, ts=100, pol=1) with out_ready=0 -> next cycle out_valid=1, out_*={5,7,100,1}, fill_level=1; these values hold for 10 cycles.
REQ-035 Push 16 events with out_ready=0, then a 17th -> fill_level=16, overflow=1, drop_count=1; draining returns events 1..16 in order.
REQ-036 Full queue, new_event and out_ready both high -> fill_level stays 16, overflow stays 0, new event is the last one out.
REQ-037 Push x=DVS_WIDTH_PXLS -> fill_level unchanged, drop_count=1, overflow=0.
REQ-038 DROP_CNT_BITS=4, 20 drops -> drop_count=15; clear_overflow in the same cycle as a drop -> drop_count=0, overflow=0.
REQ-039 Reset pulse with 5 events queued -> out_valid=0, fill_level=0 with no clock edge; the next push is the head event.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared DVS sensor geometry, timestamp width and the event word carried through the queue.
package dvs_ravens_pkg;

  localparam int unsigned DVS_X_ADDR_BITS   = 9;
  localparam int unsigned DVS_Y_ADDR_BITS   = 9;
  localparam int unsigned TIMESTAMP_US_BITS = 32;
  localparam int unsigned DVS_WIDTH_PXLS    = 346;
  localparam int unsigned DVS_HEIGHT_PXLS   = 260;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic [TIMESTAMP_US_BITS-1:0] timestamp;
    logic                         polarity;
  } dvs_event_t;

  // True when the address lies on the pixel array.
  function automatic logic dvs_in_range(logic [DVS_X_ADDR_BITS-1:0] x,
                                        logic [DVS_Y_ADDR_BITS-1:0] y);
    return (32'(x) < DVS_WIDTH_PXLS) && (32'(y) < DVS_HEIGHT_PXLS);
  endfunction

endpackage

// File: rtl/dvs_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered storage, generic over word type.
module dvs_sync_fifo #(
  parameter type         word_t = logic [7:0],
  parameter int unsigned Depth  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  word_t                    wdata,
  input  logic                     pop,
  output word_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  word_t         mem_q [Depth];
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(Depth));
  assign do_pop  = pop && !empty;
  // A full queue still takes a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Masking on empty makes the head read as zero straight out of reset.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dvs_event_fifo.sv
// DVS event queue: range-checks incoming events, buffers them and tracks drops.
module dvs_event_fifo import dvs_ravens_pkg::*; #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned DROP_CNT_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DVS_X_ADDR_BITS-1:0]     event_x,
  input  logic [DVS_Y_ADDR_BITS-1:0]     event_y,
  input  logic [TIMESTAMP_US_BITS-1:0]   event_timestamp,
  input  logic                           event_polarity,
  input  logic                           new_event,
  output logic [DVS_X_ADDR_BITS-1:0]     out_x,
  output logic [DVS_Y_ADDR_BITS-1:0]     out_y,
  output logic [TIMESTAMP_US_BITS-1:0]   out_timestamp,
  output logic                           out_polarity,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fill_level,
  output logic                           overflow,
  input  logic                           clear_overflow,
  output logic [DROP_CNT_BITS-1:0]       drop_count
);

  dvs_event_t                 wr_event, head;
  logic                       full, empty, pop, in_range, push_req, drop_full, drop;
  logic                       overflow_q;
  logic [DROP_CNT_BITS-1:0]   drop_cnt_q;

  assign wr_event  = '{x: event_x, y: event_y, timestamp: event_timestamp,
                       polarity: event_polarity};
  assign in_range  = dvs_in_range(event_x, event_y);
  assign pop       = !empty && out_ready;
  assign push_req  = new_event && in_range;
  assign drop_full = push_req && full && !pop;
  assign drop      = (new_event && !in_range) || drop_full;

  dvs_sync_fifo #(
    .word_t (dvs_event_t),
    .Depth  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (wr_event),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop_full) overflow_q <= 1'b1;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign out_valid     = !empty;
  assign out_x         = head.x;
  assign out_y         = head.y;
  assign out_timestamp = head.timestamp;
  assign out_polarity  = head.polarity;
  assign overflow      = overflow_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_dvs_event_fifo.sv
// Directed bench for dvs_event_fifo: ordering, full/overflow, range drops, saturation, reset.
module tb_dvs_event_fifo;
  import dvs_ravens_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [DVS_X_ADDR_BITS-1:0]   ev_x;
  logic [DVS_Y_ADDR_BITS-1:0]   ev_y;
  logic [TIMESTAMP_US_BITS-1:0] ev_ts;
  logic                         ev_pol, new_event, out_ready, clear_overflow;
  logic [DVS_X_ADDR_BITS-1:0]   out_x;
  logic [DVS_Y_ADDR_BITS-1:0]   out_y;
  logic [TIMESTAMP_US_BITS-1:0] out_ts;
  logic                         out_pol, out_valid, overflow;
  logic [4:0]                   fill_level;
  logic [15:0]                  drop_count;

  // Second instance with a narrow drop counter for saturation checks.
  logic [DVS_X_ADDR_BITS-1:0]   s_x;
  logic                         s_new, s_clear;
  logic [DVS_X_ADDR_BITS-1:0]   s_out_x;
  logic [DVS_Y_ADDR_BITS-1:0]   s_out_y;
  logic [TIMESTAMP_US_BITS-1:0] s_out_ts;
  logic                         s_out_pol, s_out_valid, s_overflow;
  logic [4:0]                   s_fill;
  logic [3:0]                   s_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dvs_event_fifo #(.FIFO_DEPTH(16), .DROP_CNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .event_x(ev_x), .event_y(ev_y), .event_timestamp(ev_ts),
    .event_polarity(ev_pol), .new_event(new_event), .out_x(out_x), .out_y(out_y),
    .out_timestamp(out_ts), .out_polarity(out_pol), .out_valid(out_valid),
    .out_ready(out_ready), .fill_level(fill_level), .overflow(overflow),
    .clear_overflow(clear_overflow), .drop_count(drop_count)
  );

  dvs_event_fifo #(.FIFO_DEPTH(16), .DROP_CNT_BITS(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .event_x(s_x), .event_y('0), .event_timestamp('0),
    .event_polarity(1'b0), .new_event(s_new), .out_x(s_out_x), .out_y(s_out_y),
    .out_timestamp(s_out_ts), .out_polarity(s_out_pol), .out_valid(s_out_valid),
    .out_ready(1'b0), .fill_level(s_fill), .overflow(s_overflow),
    .clear_overflow(s_clear), .drop_count(s_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then settle 1 time unit after the edge.
  task automatic step(input logic nev, input int x, input int y, input int ts, input logic pol,
                      input logic rdy, input logic clr);
    new_event = nev; ev_x = x[8:0]; ev_y = y[8:0]; ev_ts = ts; ev_pol = pol;
    out_ready = rdy; clear_overflow = clr;
    @(posedge clk); #1;
    new_event = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; new_event = 0; out_ready = 0; clear_overflow = 0;
    ev_x = '0; ev_y = '0; ev_ts = '0; ev_pol = 0; s_x = '0; s_new = 0; s_clear = 0;
    #3;
    chk("reset_valid", out_valid, 0);
    chk("reset_fill", fill_level, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_drop", drop_count, 0);
    chk("reset_out_x", out_x, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push then hold with ready low.
    step(1, 5, 7, 100, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_x", out_x, 5);
      chk("hold_y", out_y, 7);
      chk("hold_ts", out_ts, 100);
      chk("hold_pol", out_pol, 1);
      chk("hold_fill", fill_level, 1);
      @(posedge clk); #1;
    end
    step(0, 0, 0, 0, 0, 1, 0);
    chk("drain1_fill", fill_level, 0);
    chk("drain1_valid", out_valid, 0);

    // Fill to 16, overflow on the 17th, then drain in order.
    for (int i = 1; i <= 16; i++) step(1, i, i + 1, 1000 + i, i[0], 0, 0);
    chk("full_fill", fill_level, 16);
    chk("full_ovf_pre", overflow, 0);
    step(1, 17, 18, 1017, 1, 0, 0);
    chk("ovf_fill", fill_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 1);
    for (int i = 1; i <= 16; i++) begin
      chk("order_x", out_x, i);
      chk("order_y", out_y, i + 1);
      chk("order_ts", out_ts, 1000 + i);
      chk("order_pol", out_pol, i[0]);
      step(0, 0, 0, 0, 0, 1, 0);
    end
    chk("drained_valid", out_valid, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("clear_ovf", overflow, 0);
    chk("clear_drop", drop_count, 0);

    // Full queue with simultaneous push and pop.
    for (int i = 1; i <= 16; i++) step(1, i, 0, i, 0, 0, 0);
    step(1, 200, 3, 555, 1, 1, 0);
    chk("pp_fill", fill_level, 16);
    chk("pp_ovf", overflow, 0);
    chk("pp_drop", drop_count, 0);
    for (int i = 0; i < 16; i++) begin
      chk("pp_order_x", out_x, (i < 15) ? i + 2 : 200);
      step(0, 0, 0, 0, 0, 1, 0);
    end
    chk("pp_empty", fill_level, 0);

    // Out-of-range addresses.
    step(1, DVS_WIDTH_PXLS, 0, 9, 0, 0, 0);
    chk("rng_x_fill", fill_level, 0);
    chk("rng_x_drop", drop_count, 1);
    chk("rng_x_ovf", overflow, 0);
    step(1, 0, DVS_HEIGHT_PXLS, 9, 0, 0, 0);
    chk("rng_y_drop", drop_count, 2);
    chk("rng_y_valid", out_valid, 0);
    step(1, DVS_WIDTH_PXLS - 1, DVS_HEIGHT_PXLS - 1, 9, 0, 0, 0);
    chk("rng_edge_fill", fill_level, 1);
    chk("rng_edge_drop", drop_count, 2);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("rng_clear_drop", drop_count, 0);

    // Saturation on the 4-bit counter, then clear coinciding with a drop.
    for (int i = 0; i < 20; i++) begin
      s_new = 1'b1; s_x = 9'd400;
      @(posedge clk); #1;
    end
    chk("sat_drop", s_drop, 15);
    chk("sat_ovf", s_overflow, 0);
    s_clear = 1'b1;
    @(posedge clk); #1;
    s_new = 1'b0; s_clear = 1'b0;
    chk("sat_clear_drop", s_drop, 0);
    chk("sat_clear_ovf", s_overflow, 0);

    // Clear wins over an overflow drop in the same cycle.
    for (int i = 1; i <= 17; i++) step(1, i, 0, i, 0, 0, 0);
    chk("ovf2_flag", overflow, 1);
    step(1, 18, 0, 18, 0, 0, 1);
    chk("clrwin_ovf", overflow, 0);
    chk("clrwin_drop", drop_count, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("five_fill", fill_level, 5);

    // Asynchronous reset with events queued.
    rst_n = 1'b0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_fill", fill_level, 0);
    chk("arst_x", out_x, 0);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 42, 43, 4242, 1, 0, 0);
    chk("post_rst_x", out_x, 42);
    chk("post_rst_ts", out_ts, 4242);
    chk("post_rst_fill", fill_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
